// File: rtl/synarray_pkg.sv
// rtl/synarray_pkg.sv - shared sizing constants and FSM state type for the synapse array scheduler
//
// Purpose : default neuron count and the widths derived from it, plus the
//           scheduler state encoding.
// Ports   : none (package).
package synarray_pkg;

    localparam int N          = 256;
    localparam int ROW_WORDS  = N / 8;
    localparam int ADDR_W     = $clog2(N * N / 8);
    localparam int IDX_W      = $clog2(N);
    localparam int WORD_IDX_W = $clog2(ROW_WORDS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/synarray_starve_guard.sv
// rtl/synarray_starve_guard.sv - bus starvation counter forcing a grant after a bounded wait
//
// Purpose : counts consecutive cycles in which a bus request is pending but
//           not granted; force_grant rises on the last allowed wait cycle so
//           the request is granted there.
// Ports   : CLK, RST         clock, asynchronous active-high reset
//           req              bus request pending
//           gnt              bus request granted this cycle
//           force_grant      wait budget exhausted, grant must be given now
module synarray_starve_guard
    import synarray_pkg::*;
#(
    parameter int BUS_MAX_WAIT = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic req,
    input  logic gnt,
    output logic force_grant
);

    localparam int WAIT_W = (BUS_MAX_WAIT > 1) ? $clog2(BUS_MAX_WAIT) : 1;

    logic [WAIT_W-1:0] wait_cnt;

    // The counter never exceeds BUS_MAX_WAIT-1: at that value force_grant
    // makes the owner grant, which clears it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wait_cnt <= '0;
        end else if (!req || gnt) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign force_grant = (wait_cnt == WAIT_W'(BUS_MAX_WAIT - 1));

endmodule

// File: rtl/synarray_scheduler.sv
// rtl/synarray_scheduler.sv - row scan scheduler sharing a synapse SRAM with an OBI bus port
//
// Purpose : on a neuron event, reads the N/8 weight words of the event's row
//           from the synapse SRAM and streams them out; an OBI slave port
//           shares the SRAM and is starved for at most BUS_MAX_WAIT cycles.
// Ports   : CLK, RST                        clock, asynchronous active-high reset
//           evt_valid_i/evt_idx_i/evt_ready_o  event handshake and row index
//           syn_word_valid_o/idx_o/syn_word_o  returned weight words
//           evt_done_o                      one-cycle pulse at end of row scan
//           bus_*                           OBI slave port into the SRAM
//           sram_*                          single-port SRAM master
//           busy_o                          scheduler not idle
module synarray_scheduler
    import synarray_pkg::state_t;
    import synarray_pkg::IDLE;
    import synarray_pkg::SCAN;
    import synarray_pkg::DRAIN;
#(
    parameter  int N            = 256,
    parameter  int BUS_MAX_WAIT = 4,
    localparam int ROW_WORDS    = N / 8,
    localparam int ADDR_W       = $clog2(N * N / 8),
    localparam int IDX_W        = $clog2(N),
    localparam int WORD_IDX_W   = $clog2(N / 8)
) (
    input  logic                  CLK,
    input  logic                  RST,

    input  logic                  evt_valid_i,
    input  logic [IDX_W-1:0]      evt_idx_i,
    output logic                  evt_ready_o,

    output logic                  syn_word_valid_o,
    output logic [WORD_IDX_W-1:0] syn_word_idx_o,
    output logic [31:0]           syn_word_o,
    output logic                  evt_done_o,

    input  logic                  bus_req_i,
    input  logic                  bus_we_i,
    input  logic [ADDR_W-1:0]     bus_addr_i,
    input  logic [31:0]           bus_wdata_i,
    output logic                  bus_gnt_o,
    output logic                  bus_rvalid_o,
    output logic [31:0]           bus_rdata_o,

    output logic                  sram_cs_o,
    output logic                  sram_we_o,
    output logic [ADDR_W-1:0]     sram_addr_o,
    output logic [31:0]           sram_wdata_o,
    input  logic [31:0]           sram_rdata_i,

    output logic                  busy_o
);

    state_t                  state;
    logic [IDX_W-1:0]        idx;
    logic [WORD_IDX_W-1:0]   cnt;
    logic                    force_grant;
    logic                    gnt;
    logic                    issue;

    synarray_starve_guard #(
        .BUS_MAX_WAIT (BUS_MAX_WAIT)
    ) u_starve_guard (
        .CLK         (CLK),
        .RST         (RST),
        .req         (bus_req_i),
        .gnt         (gnt),
        .force_grant (force_grant)
    );

    // Outside a scan the bus owns the SRAM; during a scan it only wins once
    // its wait budget is used up, and that cycle steals the scan's slot.
    assign gnt         = bus_req_i && ((state != SCAN) || force_grant);
    assign issue       = (state == SCAN) && !gnt;
    assign bus_gnt_o   = gnt;
    assign evt_ready_o = (state == IDLE);

    always_comb begin
        sram_cs_o    = 1'b0;
        sram_we_o    = 1'b0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        if (gnt) begin
            sram_cs_o    = 1'b1;
            sram_we_o    = bus_we_i;
            sram_addr_o  = bus_addr_i;
            sram_wdata_o = bus_wdata_i;
        end else if (issue) begin
            sram_cs_o   = 1'b1;
            sram_addr_o = {idx, cnt};
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            idx        <= '0;
            cnt        <= '0;
            evt_done_o <= 1'b0;
            busy_o     <= 1'b0;
        end else begin
            evt_done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (evt_valid_i) begin
                        idx    <= evt_idx_i;
                        cnt    <= '0;
                        state  <= SCAN;
                        busy_o <= 1'b1;
                    end
                end
                SCAN: begin
                    if (issue) begin
                        // Natural wrap of cnt brings it back to 0 after the last word.
                        cnt <= cnt + 1'b1;
                        if (cnt == WORD_IDX_W'(ROW_WORDS - 1)) begin
                            state      <= DRAIN;
                            evt_done_o <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

    // SRAM read data arrives one cycle after the access, so the tags that
    // describe it are delayed by one register stage.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            syn_word_valid_o <= 1'b0;
            syn_word_idx_o   <= '0;
            bus_rvalid_o     <= 1'b0;
        end else begin
            syn_word_valid_o <= issue;
            syn_word_idx_o   <= cnt;
            bus_rvalid_o     <= gnt;
        end
    end

    assign syn_word_o  = sram_rdata_i;
    assign bus_rdata_o = sram_rdata_i;

endmodule

// File: tb/tb_synarray_scheduler.sv
// tb/tb_synarray_scheduler.sv - self-checking bench for synarray_scheduler
module tb_synarray_scheduler;

    localparam int N     = 256;
    localparam int AW    = 13;
    localparam int WORDS = 8192;

    logic        CLK = 1'b0;
    logic        RST;
    logic        evt_valid_i;
    logic [7:0]  evt_idx_i;
    logic        evt_ready_o;
    logic        syn_word_valid_o;
    logic [4:0]  syn_word_idx_o;
    logic [31:0] syn_word_o;
    logic        evt_done_o;
    logic        bus_req_i;
    logic        bus_we_i;
    logic [AW-1:0] bus_addr_i;
    logic [31:0] bus_wdata_i;
    logic        bus_gnt_o;
    logic        bus_rvalid_o;
    logic [31:0] bus_rdata_o;
    logic        sram_cs_o;
    logic        sram_we_o;
    logic [AW-1:0] sram_addr_o;
    logic [31:0] sram_wdata_o;
    logic [31:0] sram_rdata_i;
    logic        busy_o;

    always #5 CLK = ~CLK;

    synarray_scheduler #(.N(N), .BUS_MAX_WAIT(4)) dut (
        .CLK              (CLK),
        .RST              (RST),
        .evt_valid_i      (evt_valid_i),
        .evt_idx_i        (evt_idx_i),
        .evt_ready_o      (evt_ready_o),
        .syn_word_valid_o (syn_word_valid_o),
        .syn_word_idx_o   (syn_word_idx_o),
        .syn_word_o       (syn_word_o),
        .evt_done_o       (evt_done_o),
        .bus_req_i        (bus_req_i),
        .bus_we_i         (bus_we_i),
        .bus_addr_i       (bus_addr_i),
        .bus_wdata_i      (bus_wdata_i),
        .bus_gnt_o        (bus_gnt_o),
        .bus_rvalid_o     (bus_rvalid_o),
        .bus_rdata_o      (bus_rdata_o),
        .sram_cs_o        (sram_cs_o),
        .sram_we_o        (sram_we_o),
        .sram_addr_o      (sram_addr_o),
        .sram_wdata_o     (sram_wdata_o),
        .sram_rdata_i     (sram_rdata_i),
        .busy_o           (busy_o)
    );

    logic [31:0] mem    [0:WORDS-1];
    logic [31:0] shadow [0:WORDS-1];

    always @(posedge CLK) begin
        if (sram_cs_o) begin
            if (sram_we_o) mem[sram_addr_o] <= sram_wdata_o;
            else           sram_rdata_i     <= mem[sram_addr_o];
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pat(input int a);
        logic [12:0] x;
        x = a[12:0];
        return {3'b101, x, ~x, 3'b011};
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Starts an event from IDLE at posedge+1 and follows the scan to evt_done_o.
    task automatic run_scan(input int idx, input bit bus_rd, input int exp_grants,
                            input bit hold_valid, input bit entry_wr,
                            input logic [12:0] wa, input logic [31:0] wd);
        int issued = 0;
        int seen = 0;
        int grants = 0;
        int done_k = 0;
        bit pend = 0;
        logic [12:0] pend_addr = '0;
        evt_valid_i = 1'b1;
        evt_idx_i   = idx[7:0];
        if (entry_wr) begin
            bus_req_i = 1'b1; bus_we_i = 1'b1; bus_addr_i = wa; bus_wdata_i = wd;
        end
        @(negedge CLK);
        chk("accept_ready", evt_ready_o, 1'b1);
        if (entry_wr) begin
            chk("entry_wr_gnt", bus_gnt_o, 1'b1);
            chk("entry_wr_we", sram_we_o, 1'b1);
            chk("entry_wr_addr", sram_addr_o, wa);
            shadow[wa] = wd;
        end
        step();
        if (!hold_valid) evt_valid_i = 1'b0;
        if (entry_wr) begin
            bus_req_i = 1'b0; bus_we_i = 1'b0;
            chk("entry_wr_rvalid", bus_rvalid_o, 1'b1);
        end
        for (int k = 1; k <= 80; k++) begin
            if (bus_rd) begin
                bus_req_i = 1'b1; bus_we_i = 1'b0; bus_addr_i = 13'h1000 + 13'(k);
            end
            @(negedge CLK);
            if (pend) begin
                chk("bus_rvalid", bus_rvalid_o, 1'b1);
                chk("bus_rdata", bus_rdata_o, shadow[pend_addr]);
            end
            pend = 0;
            chk("scan_ready_low", evt_ready_o, 1'b0);
            chk("scan_busy", busy_o, 1'b1);
            if (bus_rd && !evt_done_o)
                chk("gnt_every4", bus_gnt_o, (k % 4 == 0));
            if (bus_gnt_o && !evt_done_o) begin
                grants++; pend = 1; pend_addr = bus_addr_i;
            end
            if (sram_cs_o && !bus_gnt_o) begin
                chk("issue_addr", sram_addr_o, 32'(idx * 32 + issued));
                chk("issue_we", sram_we_o, 1'b0);
                issued++;
            end
            if (!bus_rd)
                chk("word_valid_timing", syn_word_valid_o, (k >= 2 && k <= 33));
            if (syn_word_valid_o) begin
                chk("word_idx", syn_word_idx_o, seen);
                chk("word_data", syn_word_o, shadow[idx * 32 + seen]);
                seen++;
            end
            if (evt_done_o) done_k = k;
            step();
            if (done_k != 0) break;
        end
        bus_req_i = 1'b0;
        chk("done_cycle", done_k, 33 + exp_grants);
        chk("words_seen", seen, 32);
        chk("words_issued", issued, 32);
        chk("grants", grants, exp_grants);
        chk("done_pulse_width", evt_done_o, 1'b0);
        chk("idle_busy", busy_o, 1'b0);
    endtask

    typedef struct {
        logic        req;
        logic        we;
        logic [12:0] addr;
        logic [31:0] wdata;
        logic        gnt;
        logic        cs;
        logic        swe;
        logic [12:0] saddr;
        logic [31:0] swdata;
        logic        rv;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int dones;
        for (int a = 0; a < WORDS; a++) begin
            mem[a]    = pat(a);
            shadow[a] = pat(a);
        end
        vecs[0] = '{1'b0, 1'b0, 13'h0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 13'h0000, 32'h0000_0000, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 13'h0010, 32'h1234_5678, 1'b1, 1'b1, 1'b0, 13'h0010, 32'h1234_5678, 1'b1};
        vecs[2] = '{1'b1, 1'b1, 13'h1FFF, 32'hCAFE_F00D, 1'b1, 1'b1, 1'b1, 13'h1FFF, 32'hCAFE_F00D, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 13'h1FFF, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 13'h1FFF, 32'h0000_0000, 1'b1};
        vecs[4] = '{1'b0, 1'b1, 13'h0055, 32'h0000_FFFF, 1'b0, 1'b0, 1'b0, 13'h0000, 32'h0000_0000, 1'b0};

        RST = 1'b1;
        evt_valid_i = 1'b0; evt_idx_i = '0;
        bus_req_i = 1'b0; bus_we_i = 1'b0; bus_addr_i = '0; bus_wdata_i = '0;
        #2;
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_word_valid", syn_word_valid_o, 1'b0);
        chk("rst_word_idx", syn_word_idx_o, 5'd0);
        chk("rst_done", evt_done_o, 1'b0);
        chk("rst_rvalid", bus_rvalid_o, 1'b0);
        chk("rst_ready", evt_ready_o, 1'b1);
        chk("rst_cs", sram_cs_o, 1'b0);
        step(); step();
        RST = 1'b0;

        // Bus access while idle: grant follows request, rvalid one cycle later.
        for (int i = 0; i < 5; i++) begin
            bus_req_i = vecs[i].req; bus_we_i = vecs[i].we;
            bus_addr_i = vecs[i].addr; bus_wdata_i = vecs[i].wdata;
            @(negedge CLK);
            chk($sformatf("v%0d_gnt", i), bus_gnt_o, vecs[i].gnt);
            chk($sformatf("v%0d_cs", i), sram_cs_o, vecs[i].cs);
            chk($sformatf("v%0d_we", i), sram_we_o, vecs[i].swe);
            chk($sformatf("v%0d_addr", i), sram_addr_o, vecs[i].saddr);
            chk($sformatf("v%0d_wdata", i), sram_wdata_o, vecs[i].swdata);
            chk($sformatf("v%0d_ready", i), evt_ready_o, 1'b1);
            if (vecs[i].req && vecs[i].we) shadow[vecs[i].addr] = vecs[i].wdata;
            step();
            chk($sformatf("v%0d_rvalid", i), bus_rvalid_o, vecs[i].rv);
            if (vecs[i].rv && !vecs[i].we)
                chk($sformatf("v%0d_rdata", i), bus_rdata_o, shadow[vecs[i].addr]);
        end
        bus_req_i = 1'b0; bus_we_i = 1'b0; bus_addr_i = '0; bus_wdata_i = '0;
        step();

        // Undisturbed scan of row 5 (addresses 0x0A0..0x0BF).
        run_scan(5, 1'b0, 0, 1'b0, 1'b0, 13'h0, 32'h0);
        step();

        // Continuous bus reads during the scan of row 6: 10 grants, done at T+43.
        run_scan(6, 1'b1, 10, 1'b0, 1'b0, 13'h0, 32'h0);
        step();

        // Event and bus write to word 3 of row 7 in the same idle cycle.
        run_scan(7, 1'b0, 0, 1'b0, 1'b1, 13'h00E3, 32'hDEAD_BEEF);
        chk("wr_readback_mem", mem[13'h00E3], 32'hDEAD_BEEF);
        step();

        // Reset in the middle of a scan of row 9, at word 10.
        evt_valid_i = 1'b1; evt_idx_i = 8'd9;
        step();
        evt_valid_i = 1'b0;
        repeat (10) step();
        @(negedge CLK);
        chk("pre_rst_addr", sram_addr_o, 13'h012A);
        RST = 1'b1;
        #1;
        chk("mid_rst_busy", busy_o, 1'b0);
        chk("mid_rst_word_valid", syn_word_valid_o, 1'b0);
        chk("mid_rst_word_idx", syn_word_idx_o, 5'd0);
        chk("mid_rst_done", evt_done_o, 1'b0);
        chk("mid_rst_rvalid", bus_rvalid_o, 1'b0);
        chk("mid_rst_cs", sram_cs_o, 1'b0);
        chk("mid_rst_ready", evt_ready_o, 1'b1);
        step(); step();
        RST = 1'b0;
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            if (evt_done_o || busy_o) dones++;
            step();
        end
        chk("post_rst_quiet", dones, 0);
        run_scan(2, 1'b0, 0, 1'b0, 1'b0, 13'h0, 32'h0);
        step();

        // evt_valid_i held high: second acceptance one cycle after evt_done_o.
        run_scan(3, 1'b0, 0, 1'b1, 1'b0, 13'h0, 32'h0);
        run_scan(4, 1'b0, 0, 1'b0, 1'b0, 13'h0, 32'h0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/synarray_scheduler.md
SYNARRAY_SCHEDULER -- requirements
Module: synarray_scheduler

Interface
REQ-001 SHALL have parameter N, default 256, the neuron count; synapse words per row are N/8.
REQ-002 SHALL have parameter BUS_MAX_WAIT, default 4, the maximum number of consecutive stalled OBI request cycles during a scan, including the grant cycle.
REQ-003 SHALL have a single clock and an asynchronous, active-high reset, with ports named CLK and RST.
REQ-004 CLK  input  1  clock; all state updates on the rising edge.
REQ-005 RST  input  1  asynchronous active-high reset.
REQ-006 evt_valid_i  input  1  neuron event request.
REQ-007 evt_idx_i  input  log2(N)  presynaptic neuron index.
REQ-008 evt_ready_o  output  1  event accepted when high together with evt_valid_i.
REQ-009 syn_word_valid_o  output  1  syn_word_o and syn_word_idx_o are valid.
REQ-010 syn_word_idx_o  output  log2(N/8)  index of the returned word within the row.
REQ-011 syn_word_o  output  32  eight 4-bit weights.
REQ-012 evt_done_o  output  1  one-cycle pulse marking the end of a row scan.
REQ-013 bus_req_i, bus_we_i  input  1 each  OBI request and write enable.
REQ-014 bus_addr_i  input  log2(N*N/8)  word address.
REQ-015 bus_wdata_i  input  32  OBI write data.
REQ-016 bus_gnt_o, bus_rvalid_o  output  1 each  OBI grant and response valid.
REQ-017 bus_rdata_o  output  32  OBI read data.
REQ-018 sram_cs_o, sram_we_o  output  1 each  SRAM chip select and write enable.
REQ-019 sram_addr_o  output  log2(N*N/8)  SRAM word address.
REQ-020 sram_wdata_o  output  32  SRAM write data.
REQ-021 sram_rdata_i  input  32  SRAM read data, valid the cycle after a cs cycle.
REQ-022 busy_o  output  1  FSM is not in IDLE.

Function
REQ-023 The FSM SHALL have states IDLE, SCAN and DRAIN.
REQ-024 IDLE:
- evt_ready_o=1.
- On evt_valid_i, latch evt_idx_i, clear the word counter cnt to 0, and go to SCAN.
REQ-025 SCAN issue cycle, when no bus grant is forced:
- sram_cs_o=1, sram_we_o=0, sram_addr_o={idx,cnt}.
- cnt increments by 1.
- After issuing cnt=N/8-1, cnt wraps to 0 and the FSM goes to DRAIN.
REQ-026 DRAIN SHALL last exactly one cycle, assert evt_done_o, and return to IDLE.
REQ-027 Read returns:
- syn_word_valid_o and syn_word_idx_o SHALL be registered copies of the previous cycle's issue flag and cnt.
- syn_word_o SHALL equal sram_rdata_i.
REQ-028 Latency with no bus stalls:
- Event accepted in cycle T.
- Word 0 is issued in T+1 and returned in T+2.
- Word N/8-1 is returned in T+N/8+1, coincident with evt_done_o.
REQ-029 bus_gnt_o SHALL be combinational and equal bus_req_i in IDLE and DRAIN.
REQ-030 In SCAN, bus_gnt_o SHALL equal bus_req_i AND (wait_cnt==BUS_MAX_WAIT-1).
- A granted cycle suspends scan issue for that cycle.
- cnt holds during a granted cycle.
REQ-031 wait_cnt SHALL increment on each cycle with bus_req_i=1 and bus_gnt_o=0, and clear on a grant or when bus_req_i=0.
REQ-032 On bus grant:
- sram_cs_o=1, sram_we_o=bus_we_i, sram_addr_o=bus_addr_i, sram_wdata_o=bus_wdata_i.
- bus_rvalid_o=1 in the next cycle, for reads and writes alike.
- bus_rdata_o=sram_rdata_i.
REQ-033 With no grant and no issue, sram_cs_o=0 and the SRAM address and data outputs SHALL be 0.
REQ-034 If evt_valid_i and bus_req_i arrive in the same IDLE cycle:
- The bus is granted.
- The event is also accepted.
- The scan starts in the next cycle.
REQ-035 Bus writes to the row under scan are permitted; read-after-write ordering follows issue order.
REQ-036 evt_ready_o SHALL be 0 in SCAN and DRAIN; a new event is accepted no earlier than the cycle after evt_done_o.

Reset
REQ-037 On RST assertion, the FSM SHALL go to IDLE immediately.
REQ-038 On reset, cnt, wait_cnt, idx, syn_word_valid_o, syn_word_idx_o, evt_done_o, bus_rvalid_o and busy_o SHALL be 0.
REQ-039 A scan interrupted by reset SHALL be discarded, with no evt_done_o pulse.
REQ-040 After reset release, evt_ready_o SHALL be 1 and bus_gnt_o SHALL follow bus_req_i.

Structure
REQ-041 Package synarray_pkg SHALL hold:
- N and the derived widths ROW_WORDS=N/8, ADDR_W=log2(N*N/8), IDX_W, WORD_IDX_W.
- The state enum.
REQ-042 The starvation counter SHALL be a sub-module named synarray_starve_guard, with inputs req and gnt and output force_grant.
REQ-043 The RTL SHALL be between 150 and 300 lines.

Verification
REQ-044 Event idx=5 with the bus idle -> syn_word_valid_o for idx 0..31 on consecutive cycles from T+2, sram_addr_o 0x00A0..0x00BF, evt_done_o at T+33 only.
REQ-045 Continuous bus read requests during a scan -> bus granted every 4th cycle, rvalid one cycle later, evt_done_o at T+33+(number of grants), no word skipped or duplicated.
REQ-046 Same-cycle event and bus write in IDLE -> write granted, scan starts the following cycle, written word is read back by the scan.
REQ-047 RST asserted at word 10 -> outputs 0 within the reset cycle, no evt_done_o, the next event scans from word 0.
REQ-048 evt_valid_i held high across back-to-back events -> the second acceptance occurs exactly one cycle after evt_done_o.
